// File: rtl/csr_req_pkg.sv
// csr_req_pkg: shared CSR op/state encodings and the read-only address decode.
package csr_req_pkg;

    localparam int CSR_ADDR_W = 12;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } csr_req_state_e;

    // addr[11:10] == 2'b11 marks the read-only CSR space
    function automatic logic csr_is_ro(input logic [CSR_ADDR_W-1:0] addr);
        return (addr >> 10) == CSR_ADDR_W'(3);
    endfunction

endpackage

// File: rtl/csr_req_timer.sv
// csr_req_timer: counts stalled REQ cycles and flags the last one before abort.
module csr_req_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;

    // fires in the cycle whose increment reaches LIMIT, so access lasts at most LIMIT cycles
    assign expired = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/csr_req_master.sv
// csr_req_master: CSR command initiator toward cs_registers.
// Optional REQ timeout enabled by defining CSR_REQ_MASTER_TIMEOUT_EN.
module csr_req_master
    import csr_req_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              csr_access_o,
    output logic [1:0]        csr_op_o,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    input  logic              csr_rvalid_i,
    input  logic [DATA_W-1:0] csr_rdata_i,
    input  logic              csr_illegal_i
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    csr_req_state_e    state_q, state_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              access_q;
    logic              ready_q;
    logic              hs;
    logic              ro;
    logic              timeout;

    assign hs = cmd_valid_i && ready_q;
    assign ro = csr_is_ro(cmd_addr_i) && (cmd_op_i != CSR_OP_NONE);

`ifdef CSR_REQ_MASTER_TIMEOUT_EN
    csr_req_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != REQ),
        .en     (state_q == REQ && !csr_rvalid_i),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;

    always_comb begin
        state_d = state_q == IDLE ? (hs ? (ro ? RESP : REQ) : IDLE) :
                  state_q == REQ  ? (csr_rvalid_i || timeout ? RESP : REQ) :
                  state_q == RESP ? (rsp_ready_i ? IDLE : RESP) : IDLE;
    end

    // access and ready are registered from the next state so they only move on edges
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            access_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            access_q <= state_d == REQ;
            ready_q  <= state_d == IDLE;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (hs) begin
            op_q    <= cmd_op_i;
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
        end

    // rvalid takes priority over a coincident timeout
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (hs && ro) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (state_q == REQ && csr_rvalid_i) begin
            rdata_q <= csr_rdata_i;
            err_q   <= csr_illegal_i;
        end else if (state_q == REQ && timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end

    always_comb begin
        cmd_ready_o  = ready_q;
        csr_access_o = access_q;
        csr_op_o     = access_q ? op_q : '0;
        csr_addr_o   = access_q ? addr_q : '0;
        csr_wdata_o  = access_q ? wdata_q : '0;
        rsp_valid_o  = state_q == RESP;
        rsp_rdata_o  = state_q == RESP ? rdata_q : '0;
        rsp_err_o    = state_q == RESP && err_q;
    end

endmodule

// File: tb/tb_csr_req_master.sv
// tb_csr_req_master: directed scoreboard bench for csr_req_master.
// Timeout scenarios run when CSR_REQ_MASTER_TIMEOUT_EN is defined.
module tb_csr_req_master;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [11:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        csr_access_o;
    logic [1:0]  csr_op_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_rvalid_i;
    logic [31:0] csr_rdata_i;
    logic        csr_illegal_i;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   t_acc = 0;
    int   t_prev;

    csr_req_master #(
        .ADDR_W(12),
        .DATA_W(32),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .csr_access_o (csr_access_o),
        .csr_op_o     (csr_op_o),
        .csr_addr_o   (csr_addr_o),
        .csr_wdata_o  (csr_wdata_o),
        .csr_rvalid_i (csr_rvalid_i),
        .csr_rdata_i  (csr_rdata_i),
        .csr_illegal_i(csr_illegal_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_access"}, csr_access_o, 1'b0);
        check({tag, "_op"}, csr_op_o, 2'b00);
        check({tag, "_addr"}, csr_addr_o, 12'h000);
        check({tag, "_wdata"}, csr_wdata_o, 32'h0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [31:0] er, input logic ee);
        check("cmd_ready_before_issue", cmd_ready_o, 1'b1);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        sb.push_back('{rdata: er, err: ee});
        tick();
        t_acc       = cyc;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'b00;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
    endtask

    task automatic serve(input int d, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd, input logic ill);
        for (int i = 0; i < d; i++) begin
            check("access_wait", csr_access_o, 1'b1);
            tick();
        end
        check("access_req", csr_access_o, 1'b1);
        check("csr_op", csr_op_o, op);
        check("csr_addr", csr_addr_o, addr);
        check("csr_wdata", csr_wdata_o, wdata);
        check("rsp_valid_in_req", rsp_valid_o, 1'b0);
        csr_rvalid_i  = 1'b1;
        csr_rdata_i   = rd;
        csr_illegal_i = ill;
        tick();
        csr_rvalid_i  = 1'b0;
        csr_rdata_i   = '0;
        csr_illegal_i = 1'b0;
        check_idle_bus("bus_after_req");
    endtask

    task automatic take_rsp(input int hold, input int exp_lat);
        exp_t e;
        int   n = 0;
        while (!rsp_valid_o && n < 40) begin
            tick();
            n++;
        end
        check("rsp_valid_seen", rsp_valid_o, 1'b1);
        check("latency", 64'(cyc - t_acc + 1), 64'(exp_lat));
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 1'b0, 1'b1);
            e = '{rdata: 32'h0, err: 1'b0};
        end else begin
            e = sb.pop_front();
        end
        check("rsp_rdata", rsp_rdata_o, e.rdata);
        check("rsp_err", rsp_err_o, e.err);
        check("cmd_ready_in_resp", cmd_ready_o, 1'b0);
        check("access_in_resp", csr_access_o, 1'b0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", rsp_valid_o, 1'b1);
            check("hold_rdata", rsp_rdata_o, e.rdata);
            check("hold_err", rsp_err_o, e.err);
            check("hold_cmd_ready", cmd_ready_o, 1'b0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("rsp_valid_after", rsp_valid_o, 1'b0);
        check("rsp_rdata_after", rsp_rdata_o, 32'h0);
        check("rsp_err_after", rsp_err_o, 1'b0);
        check("cmd_ready_after", cmd_ready_o, 1'b1);
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        cmd_valid_i   = 1'b0;
        cmd_op_i      = 2'b00;
        cmd_addr_i    = '0;
        cmd_wdata_i   = '0;
        rsp_ready_i   = 1'b0;
        csr_rvalid_i  = 1'b0;
        csr_rdata_i   = '0;
        csr_illegal_i = 1'b0;

        #3;
        check("rst_cmd_ready", cmd_ready_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        check("rst_rsp_err", rsp_err_o, 1'b0);
        check_idle_bus("rst");
        tick();
        check("rst_held_cmd_ready", cmd_ready_o, 1'b0);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", cmd_ready_o, 1'b1);

        // read 0x300, rvalid one cycle after accept
        issue(2'b00, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
        serve(0, 2'b00, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
        take_rsp(0, 2);

        // write with immediate rvalid
        issue(2'b01, 12'h305, 32'hDEAD_0000, 32'h0000_1111, 1'b0);
        serve(0, 2'b01, 12'h305, 32'hDEAD_0000, 32'h0000_1111, 1'b0);
        take_rsp(0, 2);

        // SET on read-only space: no access, response next cycle
        issue(2'b10, 12'hC00, 32'h0000_00FF, 32'h0, 1'b1);
        check_idle_bus("ro_no_access");
        take_rsp(0, 1);

        // read of read-only space is legal and does access
        issue(2'b00, 12'hC01, 32'h0, 32'h0000_0042, 1'b0);
        serve(0, 2'b00, 12'hC01, 32'h0, 32'h0000_0042, 1'b0);
        take_rsp(0, 2);

        // illegal from CSR file, response held under backpressure
        issue(2'b11, 12'h7C0, 32'h0000_000F, 32'h0000_ABCD, 1'b1);
        serve(2, 2'b11, 12'h7C0, 32'h0000_000F, 32'h0000_ABCD, 1'b1);
        take_rsp(5, 4);

`ifdef CSR_REQ_MASTER_TIMEOUT_EN
        issue(2'b00, 12'h340, 32'h0, 32'h0, 1'b1);
        n = 0;
        while (csr_access_o && n < 40) begin
            n++;
            tick();
        end
        check("timeout_access_cycles", 64'(n), 64'd16);
        take_rsp(0, 17);

        // rvalid in the 16th access cycle wins over the timeout
        issue(2'b00, 12'h341, 32'h0, 32'h1234_5678, 1'b0);
        serve(15, 2'b00, 12'h341, 32'h0, 32'h1234_5678, 1'b0);
        take_rsp(0, 17);
`else
        // without the timeout, REQ waits as long as needed
        issue(2'b00, 12'h341, 32'h0, 32'h1234_5678, 1'b0);
        serve(20, 2'b00, 12'h341, 32'h0, 32'h1234_5678, 1'b0);
        take_rsp(0, 22);
`endif

        // reset during REQ drops the command
        issue(2'b01, 12'h342, 32'h5555_AAAA, 32'h0, 1'b0);
        check("access_before_reset", csr_access_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cmd_ready", cmd_ready_o, 1'b0);
        check("midrst_rsp_valid", rsp_valid_o, 1'b0);
        check_idle_bus("midrst");
        void'(sb.pop_back());
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", cmd_ready_o, 1'b1);
        check("post_rst_rsp_valid", rsp_valid_o, 1'b0);
        csr_rvalid_i = 1'b1;
        csr_rdata_i  = 32'hFFFF_FFFF;
        tick();
        csr_rvalid_i = 1'b0;
        csr_rdata_i  = '0;
        check("stray_rvalid_rsp", rsp_valid_o, 1'b0);
        check("stray_rvalid_ready", cmd_ready_o, 1'b1);
        check_idle_bus("stray_rvalid");

        // back-to-back pair at peak throughput
        issue(2'b10, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b0);
        t_prev = t_acc;
        serve(0, 2'b10, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b0);
        take_rsp(0, 2);
        issue(2'b11, 12'h300, 32'h0000_0008, 32'h0000_1808, 1'b0);
        check("throughput", 64'(t_acc - t_prev), 64'd3);
        serve(0, 2'b11, 12'h300, 32'h0000_0008, 32'h0000_1808, 1'b0);
        take_rsp(0, 2);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_req_master.md
# csr_req_master

Initiator side of the core's CSR access interface: accepts CSR commands (read, write, set, clear) on a valid/ready port and drives `csr_access`, `csr_op`, `csr_addr` and `csr_wdata` toward the CSR register file. It captures the read data and illegal flag that the file returns, then presents a response on a valid/ready port. It sits between the debug module / microcode sequencer and `cs_registers`. All outputs have defined reset values and are zero whenever no access is in flight.

## Interface
- `ADDR_W`, 12: CSR address width.
- `DATA_W`, 32: CSR data width.
- `TIMEOUT_CYC`, 16: cycles to wait for `csr_rvalid_i` before abort. Only used with the timeout feature. Legal range is 2 or more.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command accepted when both valid and ready are high.
- `cmd_op_i` in 2: 00 NONE (read only), 01 WRITE, 10 SET, 11 CLEAR.
- `cmd_addr_i` in ADDR_W: CSR address.
- `cmd_wdata_i` in DATA_W: write/set/clear operand.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out DATA_W: old CSR value.
- `rsp_err_o` out 1: illegal, read-only violation, or timeout.
- `csr_access_o` out 1: access strobe to the CSR file.
- `csr_op_o` out 2: op to the CSR file.
- `csr_addr_o` out ADDR_W: address to the CSR file.
- `csr_wdata_o` out DATA_W: operand to the CSR file.
- `csr_rvalid_i` in 1: CSR file completion.
- `csr_rdata_i` in DATA_W: CSR read data, valid with `csr_rvalid_i`.
- `csr_illegal_i` in 1: CSR file rejected the access, valid with `csr_rvalid_i`.

## Operation
- FSM states are IDLE, REQ and RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready_o`=1.
  - On handshake, latch op, addr and wdata.
  - If `addr[11:10]`==2'b11 and op!=NONE, this is a read-only violation. Go to RESP with err=1 and rdata=0. No CSR access is made.
  - Otherwise go to REQ.
- REQ:
  - `csr_access_o`=1. `csr_op_o`, `csr_addr_o` and `csr_wdata_o` are driven from the latched values and held stable.
  - On `csr_rvalid_i`=1, capture `csr_rdata_i` into rdata and `csr_illegal_i` into err, then go to RESP.
- RESP:
  - `rsp_valid_o`=1. rdata and err are held stable.
  - On `rsp_ready_i`=1, go to IDLE.
- `cmd_ready_o`=0 in REQ and RESP. Commands are never queued.
- Outside REQ, `csr_access_o`, `csr_op_o`, `csr_addr_o` and `csr_wdata_o` are all 0. Operands never leak on the CSR bus.
- `rsp_rdata_o` and `rsp_err_o` are 0 whenever `rsp_valid_o`=0.
- `csr_rvalid_i` outside REQ is ignored.
- A simultaneous timeout expiry and `csr_rvalid_i` counts as rvalid: data is captured and err=`csr_illegal_i`.
- Reset asserted mid-operation:
  - FSM returns to IDLE and all outputs go to 0 immediately.
  - The pending command is dropped and no response is emitted.

## Timing
- Reset values: `cmd_ready_o`=0 while `rst_n`=0, then 1 from the first clock edge in IDLE. All other outputs are 0.
- Command accepted at edge T: `csr_access_o` is high during cycle T+1.
- `csr_rvalid_i` sampled high at the edge ending cycle T+1: `rsp_valid_o` is high in cycle T+2. Minimum command-to-response latency is 2 cycles.
- A read-only violation gives `rsp_valid_o` in cycle T+1.
- Response handshake at edge R: `cmd_ready_o` is high in cycle R+1. Peak throughput is one command per 3 cycles.
- `csr_access_o` rises and falls only on clock edges. It is a registered output.

## Configuration
- Macro: `CSR_REQ_MASTER_TIMEOUT_EN`.
- Defined:
  - A counter of width `$clog2(TIMEOUT_CYC+1)` clears on entry to REQ and increments each REQ cycle without `csr_rvalid_i`.
  - When it reaches `TIMEOUT_CYC`, the access drops and the FSM goes to RESP with err=1 and rdata=0.
  - Access is high for at most `TIMEOUT_CYC` cycles.
- Undefined: no counter exists. REQ waits indefinitely for `csr_rvalid_i`.

## Structure
- Package `csr_req_pkg`:
  - `csr_op_e` enum: CSR_OP_NONE, CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR.
  - `csr_req_state_e` enum: IDLE, REQ, RESP.
  - Function `csr_is_ro(addr)`.
- Sub-module `csr_req_timer` holds the timeout counter (clear, enable, expired). It is instantiated only under `CSR_REQ_MASTER_TIMEOUT_EN`.

## Test plan
- Reset, then read of 0x300 (op NONE); CSR file returns rvalid one cycle later with rdata 0x1800. Expect csr_op_o=00 throughout, rsp_rdata_o=0x1800, rsp_err_o=0, latency 2 cycles.
- WRITE 0x305 with 0xDEAD0000 and immediate rvalid. Expect access for one cycle with csr_op_o=01 and csr_wdata_o=0xDEAD0000, then bus back to all-zero.
- SET on 0xC00. Expect no csr_access_o pulse, rsp_valid_o at T+1, rsp_err_o=1, rsp_rdata_o=0.
- CSR file returns csr_illegal_i=1 with rvalid. Expect rsp_err_o=1; hold rsp_ready_i low 5 cycles and confirm the response stays stable and cmd_ready_o stays 0.
- With the macro defined and TIMEOUT_CYC=16, never assert rvalid. Expect access high exactly 16 cycles, then rsp_err_o=1. Repeat with rvalid on cycle 16 and expect a normal response.
- Assert rst_n low during REQ. Expect all outputs 0 asynchronously and no response after release; then a back-to-back command pair completes normally.
